// File: rtl/i_fetch_pkg.sv
// i_fetch_pkg: shared types and constants for the instruction-fetch controller.
// The optional performance counters are enabled with the macro I_FETCH_PERF_EN.
package i_fetch_pkg;

  // Controller states. The encoding is kept here so other blocks agree on it.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RESP = 2'd2
  } fetch_state_t;

  // One cache line carries four 32-bit instruction words.
  localparam int LINE_WORDS = 4;
  localparam int SEL_W      = $clog2(LINE_WORDS);

  // Bit slices of a PC: tag selects the line, sel picks the word in the line.
  localparam int TAG_MSB = 31;
  localparam int TAG_LSB = 4;
  localparam int TAG_W   = TAG_MSB - TAG_LSB + 1;
  localparam int SEL_MSB = 3;
  localparam int SEL_LSB = 2;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0040_0000;

  // First address past the legal window. Done in 33 bits so a window that
  // touches the top of the address space cannot wrap back to a small value.
  function automatic logic [32:0] range_end(input logic [31:0] base, input int lines);
    return {1'b0, base} + (33'(lines) << 4);
  endfunction

endpackage

// File: rtl/i_fetch_linebuf.sv
// i_fetch_linebuf: single-line instruction buffer with tag compare and word mux.
// While a line is being written the mux reads the incoming line, so the
// requested word is available in the same cycle the line is captured.
module i_fetch_linebuf
  import i_fetch_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LINE_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  i_rst_n,
  input  logic                  wr_en,
  input  logic [LINE_WIDTH-1:0] wr_line,
  input  logic [TAG_W-1:0]      lookup_tag,
  input  logic [SEL_W-1:0]      word_sel,
  output logic                  hit,
  output logic [DATA_WIDTH-1:0] word
);

  logic [LINE_WIDTH-1:0] line_q;
  logic [TAG_W-1:0]      tag_q;
  logic                  valid_q;
  logic [LINE_WIDTH-1:0] src_line;

  // Capture a returned line and its tag; contents survive flushes.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      line_q  <= '0;
      tag_q   <= '0;
      valid_q <= 1'b0;
    end else if (wr_en) begin
      line_q  <= wr_line;
      tag_q   <= lookup_tag;
      valid_q <= 1'b1;
    end
  end

  assign hit = valid_q && (tag_q == lookup_tag);

  // Pick one word from either the stored line or the line being written.
  always_comb begin
    src_line = wr_en ? wr_line : line_q;
    word     = '0;
    case (word_sel)
      2'd0: word = src_line[DATA_WIDTH-1:0];
      2'd1: word = src_line[2*DATA_WIDTH-1:DATA_WIDTH];
      2'd2: word = src_line[3*DATA_WIDTH-1:2*DATA_WIDTH];
      2'd3: word = src_line[4*DATA_WIDTH-1:3*DATA_WIDTH];
      default: word = '0;
    endcase
  end

endmodule

// File: rtl/i_fetch_ctrl.sv
// i_fetch_ctrl: instruction-fetch controller with a one-line buffer.
// Hits answer one cycle after accept, misses fetch a line from the i_cache,
// bad PCs answer with an error and no cache access. flush aborts anything.
// Define I_FETCH_PERF_EN to add hit/miss/flush counters.
module i_fetch_ctrl
  import i_fetch_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter int          LINE_WIDTH = 128,
  parameter logic [31:0] BASE_ADDR  = DEFAULT_BASE_ADDR,
  parameter int          LINES      = 64
) (
  input  logic                  clk,
  input  logic                  i_rst_n,
  input  logic                  req_valid,
  input  logic [DATA_WIDTH-1:0] req_pc,
  output logic                  req_ready,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr_data,
  output logic [DATA_WIDTH-1:0] instr_pc,
  output logic                  instr_err,
  input  logic                  flush,
  output logic                  cache_rd_en,
  output logic [DATA_WIDTH-1:0] cache_pc,
  output logic                  cache_abort,
  input  logic [LINE_WIDTH-1:0] cache_dout,
  input  logic                  cache_dout_valid
`ifdef I_FETCH_PERF_EN
  ,
  output logic [31:0]           perf_hits,
  output logic [31:0]           perf_misses,
  output logic [31:0]           perf_flushes
`endif
);

  localparam logic [32:0] END_ADDR = range_end(BASE_ADDR, LINES);

  fetch_state_t          state;
  logic [DATA_WIDTH-1:0] pc_q;
  logic                  req_err;
  logic                  fill_done;
  logic                  lb_hit;
  logic [DATA_WIDTH-1:0] lb_word;
  logic [TAG_W-1:0]      lookup_tag;
  logic [SEL_W-1:0]      word_sel;

  // Classify the incoming PC and steer the line-buffer lookup address.
  always_comb begin
    req_err = (req_pc[1:0] != 2'b00)
           || (req_pc < BASE_ADDR)
           || ({1'b0, req_pc} >= END_ADDR);
    fill_done  = (state == FILL) && cache_dout_valid && !flush;
    lookup_tag = (state == FILL) ? pc_q[TAG_MSB:TAG_LSB] : req_pc[TAG_MSB:TAG_LSB];
    word_sel   = (state == FILL) ? pc_q[SEL_MSB:SEL_LSB] : req_pc[SEL_MSB:SEL_LSB];
  end

  i_fetch_linebuf #(
    .DATA_WIDTH (DATA_WIDTH),
    .LINE_WIDTH (LINE_WIDTH)
  ) u_linebuf (
    .clk        (clk),
    .i_rst_n    (i_rst_n),
    .wr_en      (fill_done),
    .wr_line    (cache_dout),
    .lookup_tag (lookup_tag),
    .word_sel   (word_sel),
    .hit        (lb_hit),
    .word       (lb_word)
  );

  // Fetch FSM with all handshake and cache outputs registered; flush wins over everything.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      pc_q        <= '0;
      req_ready   <= 1'b1;
      instr_valid <= 1'b0;
      instr_data  <= '0;
      instr_pc    <= '0;
      instr_err   <= 1'b0;
      cache_rd_en <= 1'b0;
      cache_pc    <= '0;
      cache_abort <= 1'b0;
    end else begin
      cache_abort <= 1'b0;
      if (flush) begin
        cache_abort <= (state == FILL);
        state       <= IDLE;
        req_ready   <= 1'b1;
        instr_valid <= 1'b0;
        cache_rd_en <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (req_valid) begin
              pc_q      <= req_pc;
              req_ready <= 1'b0;
              if (req_err) begin
                state       <= RESP;
                instr_valid <= 1'b1;
                instr_data  <= '0;
                instr_pc    <= req_pc;
                instr_err   <= 1'b1;
              end else if (lb_hit) begin
                state       <= RESP;
                instr_valid <= 1'b1;
                instr_data  <= lb_word;
                instr_pc    <= req_pc;
                instr_err   <= 1'b0;
              end else begin
                state       <= FILL;
                cache_rd_en <= 1'b1;
                cache_pc    <= req_pc;
              end
            end
          end
          FILL: begin
            if (cache_dout_valid) begin
              state       <= RESP;
              cache_rd_en <= 1'b0;
              instr_valid <= 1'b1;
              instr_data  <= lb_word;
              instr_pc    <= pc_q;
              instr_err   <= 1'b0;
            end
          end
          RESP: begin
            if (instr_ready) begin
              state       <= IDLE;
              instr_valid <= 1'b0;
              req_ready   <= 1'b1;
            end
          end
          default: begin
            state       <= IDLE;
            req_ready   <= 1'b1;
            instr_valid <= 1'b0;
            cache_rd_en <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef I_FETCH_PERF_EN
  // Free-running event counters; they wrap naturally at 2^32.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      perf_hits    <= '0;
      perf_misses  <= '0;
      perf_flushes <= '0;
    end else if (flush) begin
      perf_flushes <= perf_flushes + 32'd1;
    end else if ((state == IDLE) && req_valid && !req_err) begin
      if (lb_hit) begin
        perf_hits <= perf_hits + 32'd1;
      end else begin
        perf_misses <= perf_misses + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_i_fetch_ctrl.sv
// tb_i_fetch_ctrl: directed, scoreboard-based bench for i_fetch_ctrl.
// Also checks the counters when built with I_FETCH_PERF_EN.
module tb_i_fetch_ctrl;

  localparam logic [31:0] BASE = 32'h0040_0000;
  localparam logic [32:0] ENDA = 33'h0_0040_0400;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] pc;
    logic        err;
  } exp_t;

  logic         clk = 1'b0;
  logic         i_rst_n = 1'b0;
  logic         req_valid = 1'b0;
  logic [31:0]  req_pc = '0;
  logic         req_ready;
  logic         instr_valid;
  logic         instr_ready = 1'b0;
  logic [31:0]  instr_data;
  logic [31:0]  instr_pc;
  logic         instr_err;
  logic         flush = 1'b0;
  logic         cache_rd_en;
  logic [31:0]  cache_pc;
  logic         cache_abort;
  logic [127:0] cache_dout = '0;
  logic         cache_dout_valid = 1'b0;
`ifdef I_FETCH_PERF_EN
  logic [31:0]  perf_hits, perf_misses, perf_flushes;
`endif

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  // Reference model of the line buffer and the event counts.
  logic        m_valid = 1'b0;
  logic [27:0] m_tag = '0;
  int          m_hits = 0, m_misses = 0, m_flushes = 0;

  always #5 clk = ~clk;

  i_fetch_ctrl dut (
    .clk              (clk),
    .i_rst_n          (i_rst_n),
    .req_valid        (req_valid),
    .req_pc           (req_pc),
    .req_ready        (req_ready),
    .instr_valid      (instr_valid),
    .instr_ready      (instr_ready),
    .instr_data       (instr_data),
    .instr_pc         (instr_pc),
    .instr_err        (instr_err),
    .flush            (flush),
    .cache_rd_en      (cache_rd_en),
    .cache_pc         (cache_pc),
    .cache_abort      (cache_abort),
    .cache_dout       (cache_dout),
    .cache_dout_valid (cache_dout_valid)
`ifdef I_FETCH_PERF_EN
    ,
    .perf_hits        (perf_hits),
    .perf_misses      (perf_misses),
    .perf_flushes     (perf_flushes)
`endif
  );

  // Read-only instruction memory contents: every word derives from its address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[31:2], 2'b00} ^ 32'h5A5A_A5A5;
  endfunction

  function automatic logic [127:0] make_line(input logic [31:0] pc);
    logic [31:0] b;
    b = {pc[31:4], 4'h0};
    return {mem_word(b + 32'd12), mem_word(b + 32'd8), mem_word(b + 32'd4), mem_word(b)};
  endfunction

  function automatic logic is_err(input logic [31:0] pc);
    return (pc[1:0] != 2'b00) || (pc < BASE) || ({1'b0, pc} >= ENDA);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_instr_valid"}, instr_valid, 0);
    checkOutput({tag, "_instr_data"}, instr_data, 0);
    checkOutput({tag, "_instr_pc"}, instr_pc, 0);
    checkOutput({tag, "_instr_err"}, instr_err, 0);
    checkOutput({tag, "_cache_rd_en"}, cache_rd_en, 0);
    checkOutput({tag, "_cache_pc"}, cache_pc, 0);
    checkOutput({tag, "_cache_abort"}, cache_abort, 0);
    checkOutput({tag, "_req_ready"}, req_ready, 1);
  endtask

  task automatic checkPerf();
`ifdef I_FETCH_PERF_EN
    checkOutput("perf_hits", perf_hits, m_hits);
    checkOutput("perf_misses", perf_misses, m_misses);
    checkOutput("perf_flushes", perf_flushes, m_flushes);
`endif
  endtask

  // One complete fetch: request, optional cache stall, hold in RESP, release.
  task automatic applyStimulus(input logic [31:0] pc, input int stall, input int hold);
    exp_t e;
    logic err, hit;
    int   lat, rd, waited, exp_lat, exp_rd;
    err = is_err(pc);
    hit = !err && m_valid && (m_tag == pc[31:4]);
    exp_lat = (err || hit) ? 1 : stall + 2;
    exp_rd  = (err || hit) ? 0 : stall + 1;
    @(negedge clk);
    checkOutput("req_ready_idle", req_ready, 1);
    req_valid = 1'b1;
    req_pc    = pc;
    sb.push_back('{data: err ? 32'h0 : mem_word(pc), pc: pc, err: err});
    if (!err) begin
      if (hit) m_hits++;
      else begin m_misses++; m_valid = 1'b1; m_tag = pc[31:4]; end
    end
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1; rd = 0; waited = 0;
    while (!instr_valid && lat < 50) begin
      checkOutput("req_ready_busy", req_ready, 0);
      if (cache_rd_en) begin
        rd++;
        checkOutput("cache_pc", cache_pc, pc);
        cache_dout = make_line(pc);
        if (waited >= stall) cache_dout_valid = 1'b1;
        else waited++;
      end
      @(negedge clk);
      cache_dout_valid = 1'b0;
      lat++;
    end
    checkOutput("latency", lat, exp_lat);
    checkOutput("rd_cycles", rd, exp_rd);
    if (sb.size() == 0) begin
      checkOutput("sb_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      for (int i = 0; i <= hold; i++) begin
        checkOutput("instr_valid", instr_valid, 1);
        checkOutput("instr_data", instr_data, e.data);
        checkOutput("instr_pc", instr_pc, e.pc);
        checkOutput("instr_err", instr_err, e.err);
        checkOutput("req_ready_resp", req_ready, 0);
        checkOutput("rd_en_resp", cache_rd_en, 0);
        if (i < hold) @(negedge clk);
      end
    end
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    checkOutput("valid_after_ready", instr_valid, 0);
    checkOutput("req_ready_after", req_ready, 1);
  endtask

  initial begin
    $display("[TB] start");
    #12;
    checkResetValues("reset");
    @(negedge clk);
    i_rst_n = 1'b1;
    checkPerf();

    // Miss, hit, error and stall cases.
    applyStimulus(32'h0040_0008, 0, 0);
    applyStimulus(32'h0040_000C, 0, 0);
    applyStimulus(32'h0040_0002, 0, 0);
    applyStimulus(32'h003F_FFFC, 0, 0);
    applyStimulus(32'h0040_0000, 0, 5);

    // Miss stalled for three cycles, then flushed.
    @(negedge clk);
    req_valid = 1'b1;
    req_pc    = 32'h0040_0040;
    m_misses++;
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkOutput("stall_rd_en", cache_rd_en, 1);
      checkOutput("stall_abort", cache_abort, 0);
      checkOutput("stall_valid", instr_valid, 0);
      if (i < 2) @(negedge clk);
    end
    flush = 1'b1;
    m_flushes++;
    @(negedge clk);
    flush = 1'b0;
    checkOutput("flush_abort", cache_abort, 1);
    checkOutput("flush_valid", instr_valid, 0);
    checkOutput("flush_req_ready", req_ready, 1);
    checkOutput("flush_rd_en", cache_rd_en, 0);
    @(negedge clk);
    checkOutput("abort_one_cycle", cache_abort, 0);
    checkOutput("flush_valid2", instr_valid, 0);
    applyStimulus(32'h0040_0004, 0, 0);

    // flush beats a simultaneous request.
    @(negedge clk);
    req_valid = 1'b1;
    req_pc    = 32'h0040_0000;
    flush     = 1'b1;
    m_flushes++;
    @(negedge clk);
    req_valid = 1'b0;
    flush     = 1'b0;
    checkOutput("flush_prio_valid", instr_valid, 0);
    checkOutput("flush_prio_ready", req_ready, 1);
    checkOutput("flush_prio_abort", cache_abort, 0);

    // Range boundaries and a stalled miss followed by a hit.
    applyStimulus(32'h0040_03FC, 0, 0);
    applyStimulus(32'h0040_0400, 0, 0);
    applyStimulus(32'hFFFF_FFFC, 0, 0);
    applyStimulus(32'h0040_0100, 2, 1);
    applyStimulus(32'h0040_0104, 0, 0);
    checkPerf();

    // Asynchronous reset in the middle of a fill.
    @(negedge clk);
    req_valid = 1'b1;
    req_pc    = 32'h0040_0200;
    @(negedge clk);
    req_valid = 1'b0;
    checkOutput("pre_reset_rd_en", cache_rd_en, 1);
    #2;
    i_rst_n = 1'b0;
    #1;
    checkResetValues("async_reset");
    m_valid = 1'b0; m_hits = 0; m_misses = 0; m_flushes = 0;
    checkPerf();
    @(negedge clk);
    i_rst_n = 1'b1;
    applyStimulus(32'h0040_0100, 0, 0);
    checkPerf();
    checkOutput("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i_fetch_ctrl.md
I_FETCH_CTRL -- requirements
Module: i_fetch_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 32, instruction/PC width.
REQ-002 Parameter LINE_WIDTH, default 128, instruction-cache line width (4 words).
REQ-003 Parameter BASE_ADDR, default 32'h0040_0000, lowest legal fetch address.
REQ-004 Parameter LINES, default 64, number of cache lines; legal range is BASE_ADDR .. BASE_ADDR+LINES*16-1.
REQ-005 Clock and reset: one clock `clk`; reset `i_rst_n` is asynchronous, active-low.
REQ-006 Ports:
- clk  in  1  clock
- i_rst_n  in  1  async active-low reset
- req_valid  in  1  fetch-stage PC request
- req_pc  in  32  requested PC
- req_ready  out  1  controller accepts request
- instr_valid  out  1  instruction response valid
- instr_ready  in  1  decode accepts response
- instr_data  out  32  fetched instruction
- instr_pc  out  32  PC of instr_data
- instr_err  out  1  misaligned or out-of-range PC
- flush  in  1  branch/abort; kills in-flight fetch
- cache_rd_en  out  1  i_cache read enable
- cache_pc  out  32  i_cache address
- cache_abort  out  1  i_cache abort
- cache_dout  in  128  i_cache line
- cache_dout_valid  in  1  line valid

Function
REQ-007 FSM states: IDLE, FILL, RESP; encoding lives in the package.
REQ-008 The line buffer holds one 128-bit line, a tag (PC[31:4]) and lbuf_valid.
REQ-009 IDLE: req_ready=1; on req_valid the controller latches req_pc.
- Hit: lbuf_valid and tag match -> RESP next cycle (latency 1).
- Miss -> FILL.
REQ-010 FILL: req_ready=0; cache_rd_en=1, cache_pc=latched PC.
- When cache_dout_valid=1, capture line and tag, set lbuf_valid -> RESP next cycle.
- Miss latency is 2 cycles when cache_dout_valid is high in FILL.
REQ-011 FILL with cache_dout_valid=0 stays in FILL with cache_rd_en held at 1.
REQ-012 Word select: PC[3:2]=0 -> bits [31:0], PC[3:2]=3 -> [127:96].
REQ-013 RESP: instr_valid=1; instr_data, instr_pc and instr_err stay stable until instr_ready=1.
- On instr_ready=1 -> IDLE.
- req_ready=0 in RESP; no back-to-back accept.
REQ-014 Error requests go directly to RESP with instr_err=1 and instr_data=0; no cache access, line buffer untouched.
- Error cases: PC[1:0]!=0, PC<BASE_ADDR, or PC>=BASE_ADDR+LINES*16.
REQ-015 flush in any state -> IDLE next cycle.
- instr_valid deasserts the next cycle.
- cache_abort=1 for that cycle if the state was FILL.
- The line buffer is retained, since memory is read-only.
REQ-016 flush has priority over a simultaneous req_valid, cache_dout_valid or instr_ready.
REQ-017 PC comparisons are unsigned 32-bit; the end-of-range sum is computed in 33 bits so it cannot wrap.

Reset
REQ-018 Reset: state=IDLE, lbuf_valid=0, line/tag=0.
REQ-019 Output reset values: instr_valid=0, instr_data=0, instr_pc=0, instr_err=0, cache_rd_en=0, cache_pc=0, cache_abort=0, req_ready=1.
REQ-020 Reset asserted mid-FILL or mid-RESP drops the transaction with no response.

Configuration
REQ-021 With macro I_FETCH_PERF_EN defined, the block has three 32-bit outputs:
- perf_hits: increments on a hit in IDLE.
- perf_misses: increments on FILL entry.
- perf_flushes: increments on flush.
- All three reset to 0 and wrap at 2^32.
REQ-022 Without I_FETCH_PERF_EN, the counter ports and logic are absent and the rest of the behaviour is identical.

Structure
REQ-023 Package i_fetch_pkg holds the FSM state enum, LINE_WORDS=4, the tag/offset bit-slice constants and the default BASE_ADDR.
REQ-024 Sub-module i_fetch_linebuf holds the line/tag/valid registers, tag compare and word mux; the FSM stays in the top.

Verification
REQ-025 Reset, then req_pc=32'h0040_0008 with cache_dout_valid=1 -> cache_rd_en for 1 cycle; instr_valid 2 cycles after accept; instr_data=line[95:64].
REQ-026 Next req_pc=32'h0040_000C -> hit, no cache_rd_en, instr_valid 1 cycle after accept, instr_data=line[127:96].
REQ-027 req_pc=32'h0040_0002 and 32'h003F_FFFC -> instr_err=1, instr_data=0, cache_rd_en never asserted.
REQ-028 Miss with cache_dout_valid held 0 for 3 cycles, then flush -> cache_abort=1 for one cycle, IDLE next cycle, no instr_valid, lbuf_valid unchanged.
REQ-029 instr_ready held 0 for 5 cycles in RESP -> instr_data/instr_pc stable, req_ready=0; released -> IDLE.
REQ-030 With I_FETCH_PERF_EN: 1 miss, 3 hits, 1 flush -> perf_misses=1, perf_hits=3, perf_flushes=1; async reset mid-FILL -> all outputs at reset values immediately.
